// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch stage.
//   WORD_W / ADDR_W : instruction and word-address widths
//   fetch_state_e   : fetch FSM state encoding
//   sat_inc16       : saturating 16-bit increment used by the optional statistics counters
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDrop = 2'd3
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of {pc, instr} pairs between fetch and decode.
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_pc/instr   : write one entry (ignored when full without a pop, or on flush)
//   pop                   : drop head entry (ignored when empty or on flush)
//   flush                 : empty the FIFO; wins over push and pop
//   count                 : number of valid entries
//   head_pc, head_instr   : head entry contents (zero after reset)
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic [WORD_W-1:0]          push_instr,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(BUF_DEPTH):0] count,
  output logic [ADDR_W-1:0]          head_pc,
  output logic [WORD_W-1:0]          head_instr
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(BUF_DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [ADDR_W-1:0] pc_mem_q    [BUF_DEPTH];
  logic [WORD_W-1:0] instr_mem_q [BUF_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && !flush && (count_q != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    do_push  = push && !flush && ((count_q != CntFull) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (do_push && !do_pop)      count_d = count_q + CntOne;
      else if (!do_push && do_pop) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        pc_mem_q[wr_ptr_q]    <= push_pc;
        instr_mem_q[wr_ptr_q] <= push_instr;
      end
    end
  end

  assign count      = count_q;
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the program counter and decode.
// Issues one word-addressed read at a time, steers the PC (increment on an accepted
// request, load on redirect) and queues fetched instructions tagged with their PC.
//   clk, reset                       : clock, asynchronous active-high reset
//   pc_cur                           : current PC
//   pc_enable, pc_load, pc_next      : PC update strobe, load select, load address
//   imem_req/addr/ready              : read request handshake (addr = pc_cur)
//   imem_rvalid, imem_rdata          : read response
//   instr_valid/instr/instr_pc/ready : buffer head to decode
//   redirect, redirect_addr          : taken branch from execute (one-cycle pulse)
// Optional build macro IFETCH_STATS_EN adds stat_fetched / stat_stall saturating counters.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pc_enable,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
`ifdef IFETCH_STATS_EN
  output logic [15:0]       stat_fetched,
  output logic [15:0]       stat_stall,
`endif
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(BUF_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
  logic [CntW-1:0]   buf_count;
  logic [CntW:0]     count_after;
  logic              push, pop, flush, accept, room;

  fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_pc   (pending_pc_q),
    .push_instr(imem_rdata),
    .pop       (pop),
    .flush     (flush),
    .count     (buf_count),
    .head_pc   (instr_pc),
    .head_instr(instr)
  );

  assign instr_valid = (buf_count != '0);
  assign imem_addr   = pc_cur;

  always_comb begin
    flush       = redirect;
    push        = !redirect && (state_q == StWait) && imem_rvalid;
    pop         = !redirect && instr_valid && instr_ready;
    count_after = {1'b0, buf_count} + {{CntW{1'b0}}, push} - {{CntW{1'b0}}, pop};
    room        = (count_after < DepthExt);
    imem_req    = !redirect && (state_q == StReq);
    accept      = imem_req && imem_ready;
    pc_enable   = redirect || accept;
    pc_load     = redirect;
    pc_next     = redirect ? redirect_addr : '0;
    pending_pc_d = accept ? pc_cur : pending_pc_q;
    state_d     = state_q;
    if (redirect) begin
      // A read still in flight must be drained; if it lands now there is nothing to drop.
      if ((state_q == StWait || state_q == StDrop) && !imem_rvalid) state_d = StDrop;
      else                                                          state_d = StReq;
    end else begin
      unique case (state_q)
        StIdle:  if (room) state_d = StReq;
        StReq:   if (imem_ready) state_d = StWait;
        StWait:  if (imem_rvalid) state_d = room ? StReq : StIdle;
        StDrop:  if (imem_rvalid) state_d = StReq;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_pc_q <= pending_pc_d;
    end
  end

`ifdef IFETCH_STATS_EN
  logic [15:0] stat_fetched_q, stat_fetched_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_fetched_d = push ? sat_inc16(stat_fetched_q) : stat_fetched_q;
    stat_stall_d   = (instr_valid && !instr_ready) ? sat_inc16(stat_stall_q) : stat_stall_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench for instruction_fetch with a queue-based reference
// model, a program-counter model and a variable-latency memory model, plus directed scenarios
// whose results are pinned with hand-computed literals.
`timescale 1ns/1ps
module tb_instruction_fetch;

  localparam int unsigned BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_cur;
  logic        pc_enable, pc_load;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr, instr_pc;
  logic        instr_ready, redirect;
  logic [15:0] redirect_addr;
`ifdef IFETCH_STATS_EN
  logic [15:0] stat_fetched, stat_stall;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_cur       (pc_cur),
    .pc_enable    (pc_enable),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
`ifdef IFETCH_STATS_EN
    .stat_fetched (stat_fetched),
    .stat_stall   (stat_stall),
`endif
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued {pc, instr}; a read is either wanted, in flight, or in flight
  // but stale.
  logic [31:0] m_q[$];
  bit          m_armed, m_busy, m_drop;
  logic [15:0] m_pend;
  int          m_fetched, m_stall;

  // Environment: program counter and single-outstanding memory with random latency.
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr, pc_nxt;
  int unsigned lat_min = 1, lat_max = 1, p_ready = 100, p_iready = 100, p_redir = 0;

  // Per-cycle logs since the last reset (index 0 = first cycle after release).
  logic [31:0] cons[$];
  logic [15:0] log_req[$], log_en[$], log_load[$], log_next[$], log_valid[$], log_addr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat16(input int v);
    return (v > 65535) ? 32'd65535 : 32'(v);
  endfunction

  task automatic model_step();
    bit          exp_valid, exp_req, acc;
    logic [31:0] head;
    exp_valid = (m_q.size() != 0);
    exp_req   = m_armed && !redirect;
    acc       = exp_req && imem_ready;
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      head = m_q[0];
      check("instr_pc", instr_pc, head[31:16]);
      check("instr", instr, head[15:0]);
    end
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, pc_cur);
    check("pc_enable", pc_enable, redirect || acc);
    check("pc_load", pc_load, redirect);
    check("pc_next", pc_next, redirect ? redirect_addr : 16'h0000);
`ifdef IFETCH_STATS_EN
    check("stat_fetched", stat_fetched, sat16(m_fetched));
    check("stat_stall", stat_stall, sat16(m_stall));
`endif
    log_req.push_back(16'(imem_req));
    log_en.push_back(16'(pc_enable));
    log_load.push_back(16'(pc_load));
    log_next.push_back(pc_next);
    log_valid.push_back(16'(instr_valid));
    log_addr.push_back(imem_addr);
    if (exp_valid && !instr_ready) m_stall++;
    if (exp_valid && instr_ready && !redirect) cons.push_back({instr_pc, instr});

    if (redirect) begin
      m_q.delete();
      if (m_busy && !imem_rvalid) begin
        m_drop  = 1'b1;
        m_armed = 1'b0;
      end else begin
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_armed = 1'b1;
      end
    end else begin
      if (exp_valid && instr_ready) void'(m_q.pop_front());
      if (m_busy && imem_rvalid) begin
        if (!m_drop) begin
          m_q.push_back({m_pend, imem_rdata});
          m_fetched++;
          m_armed = (m_q.size() < int'(BUF_DEPTH));
        end else begin
          m_armed = 1'b1;
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else if (m_armed) begin
        if (acc) begin
          m_busy  = 1'b1;
          m_armed = 1'b0;
          m_pend  = pc_cur;
        end
      end else if (!m_busy) begin
        m_armed = (m_q.size() < int'(BUF_DEPTH));
      end
    end
  endtask

  task automatic env_step();
    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (imem_req && imem_ready) begin
      mem_busy = 1'b1;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
      mem_addr = imem_addr;
    end
    pc_nxt = pc_enable ? (pc_load ? pc_next : pc_cur + 16'd1) : pc_cur;
  endtask

  task automatic drive();
    pc_cur        = pc_nxt;
    imem_ready    = ($urandom_range(99) < p_ready);
    instr_ready   = ($urandom_range(99) < p_iready);
    redirect      = ($urandom_range(99) < p_redir);
    redirect_addr = ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom);
    imem_rvalid   = mem_busy && (mem_cnt == 1);
    imem_rdata    = imem_rvalid ? (16'hA000 + mem_addr) : 16'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    env_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_addr = '0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    instr_ready   = 1'b0;
    pc_cur        = '0;
    pc_nxt        = '0;
    m_q.delete();
    m_armed = 1'b0; m_busy = 1'b0; m_drop = 1'b0; m_pend = '0;
    m_fetched = 0; m_stall = 0;
    cons.delete();
    log_req.delete(); log_en.delete(); log_load.delete();
    log_next.delete(); log_valid.delete(); log_addr.delete();
    // A read in flight across reset still answers, right after release.
    if (mem_busy) mem_cnt = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_enable", pc_enable, 1'b0);
    check("rst_pc_load", pc_load, 1'b0);
    check("rst_pc_next", pc_next, 16'h0000);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
`ifdef IFETCH_STATS_EN
    check("rst_stat_fetched", stat_fetched, 16'h0000);
    check("rst_stat_stall", stat_stall, 16'h0000);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
  endtask

  task automatic check_cons(input string name, input int idx, input logic [31:0] exp);
    if (cons.size() > idx) check(name, cons[idx], exp);
    else check(name, 32'hDEAD_0000 | 32'(cons.size()), exp);
  endtask

  initial begin
    int sum;
    int guard;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr = '0;

    // Straight-line fetch, 1-cycle memory, decode always ready.
    lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
    do_reset();
    repeat (12) step();
    check("t1_req_c1", 32'(log_req[0]), 32'd0);
    check("t1_req_c2", 32'(log_req[1]), 32'd1);
    sum = 0;
    for (int i = 0; i < 12; i++) sum += int'(log_en[i]) + int'(log_load[i]);
    check("t1_pc_enables", 32'(sum), 32'd6);
    check("t1_first_valid", 32'(log_valid[3]), 32'd1);
    check_cons("t1_i0", 0, 32'h0000_A000);
    check_cons("t1_i1", 1, 32'h0001_A001);
    check_cons("t1_i2", 2, 32'h0002_A002);
    check_cons("t1_i3", 3, 32'h0003_A003);

    // Decode stalled: buffer fills to two and fetching stops at PC 2.
    p_iready = 0;
    do_reset();
    repeat (14) step();
    check("t2_pc_stop", pc_cur, 16'd2);
    sum = 0;
    for (int i = 5; i < 14; i++) sum += int'(log_req[i]);
    check("t2_req_idle", 32'(sum), 32'd0);
    check("t2_valid_held", instr_valid, 1'b1);
    p_iready = 100;
    repeat (12) step();
    check_cons("t2_i0", 0, 32'h0000_A000);
    check_cons("t2_i1", 1, 32'h0001_A001);
    check_cons("t2_i2", 2, 32'h0002_A002);

    // Memory not ready for three request cycles.
    p_ready = 0;
    do_reset();
    repeat (3) step();
    p_ready = 100;
    repeat (6) step();
    check("t3_req_hold", 32'(log_req[1] + log_req[2] + log_req[3]), 32'd3);
    check("t3_addr_hold", 32'(log_addr[1] | log_addr[2] | log_addr[3]), 32'd0);
    check("t3_no_enable", 32'(log_en[1] + log_en[2] + log_en[3]), 32'd0);
    check("t3_accept_en", 32'(log_en[4]), 32'd1);
    check_cons("t3_i0", 0, 32'h0000_A000);

    // Redirect while a 3-cycle read is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (2) step();
    redirect      = 1'b1;
    redirect_addr = 16'h0040;
    step();
    check("t4_pc_load", 32'(log_load[2]), 32'd1);
    check("t4_pc_next", 32'(log_next[2]), 32'h0040);
    repeat (14) step();
    check_cons("t4_i0", 0, 32'h0040_A040);

    // Redirect in the same cycle as read data that would fill the buffer.
    lat_min = 1; lat_max = 1; p_iready = 0;
    do_reset();
    repeat (4) step();
    check("t5_rvalid_now", imem_rvalid, 1'b1);
    redirect      = 1'b1;
    redirect_addr = 16'h0100;
    p_iready      = 100;
    step();
    step();
    check("t5_valid_before", 32'(log_valid[4]), 32'd1);
    check("t5_valid_after", 32'(log_valid[5]), 32'd0);
    repeat (8) step();
    check_cons("t5_i0", 0, 32'h0100_A100);

`ifdef IFETCH_STATS_EN
    // Four stall cycles, then run until ten instructions have been pushed.
    p_iready = 0;
    do_reset();
    repeat (6) step();
    p_iready = 100;
    step();
    guard = 0;
    while (m_fetched < 10 && guard < 100) begin
      step();
      guard++;
    end
    #3;
    check("t6_stat_fetched", stat_fetched, 16'd10);
    check("t6_stat_stall", stat_stall, 16'd4);
`endif

    // Randomized traffic with a reset landing on an outstanding read.
    lat_min = 1; lat_max = 3; p_ready = 70; p_iready = 60; p_redir = 4;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        guard = 0;
        while (!mem_busy && guard < 50) begin
          step();
          guard++;
        end
        check("t7_inflight_at_reset", 32'(mem_busy), 32'd1);
        do_reset();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
